// File: rtl/seq_gen_tx.sv
// ---------------------------------------------------------------------------
// seq_gen_tx
//
// Framed serial transmitter with a frame repeat count.  A load latches a
// WIDTH-bit payload plus a repeat count.  The block then sends 1 to 4
// identical frames back to back.  Each frame is:
//   start (x=1), WIDTH data bits MSB first, stop (x=0).
// Every bit is held for CLKS_PER_BIT clocks.  When the block is idle, x
// rests at 0.
//
// Parameters
//   WIDTH         data bits per frame (>= 1)
//   CLKS_PER_BIT  clocks each serial bit is held (>= 1)
//
// Ports
//   clk       clock; all state changes on its rising edge
//   rst       synchronous, active-high reset
//   in_valid  load request present on in_data / in_rep
//   in_ready  block is IDLE and will accept a load this cycle
//   in_data   payload to serialize
//   in_rep    number of frames minus one (0..3)
//   x         registered serial line output
//   busy      transmission in progress (inverse of in_ready)
//   done      one-cycle pulse on the final cycle of the last stop bit
// ---------------------------------------------------------------------------
module seq_gen_tx #(
   parameter int WIDTH        = 8,
   parameter int CLKS_PER_BIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_rep,
   output logic             x,
   output logic             busy,
   output logic             done
);

   // Counter widths are kept at least one bit, so that WIDTH=1 and
   // CLKS_PER_BIT=1 still produce legal vectors.
   localparam int PW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [PW-1:0] PER_LAST = PW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] shreg, shreg_nx;
   logic [WIDTH-1:0] hold, hold_nx;     // untouched copy of the payload, reused on every repeat
   logic [BW-1:0]    bit_cnt, bit_cnt_nx;
   logic [PW-1:0]    per_cnt, per_cnt_nx;
   logic [1:0]       rep_cnt, rep_cnt_nx;
   logic             x_nx;
   logic             bit_end;

   // bit_end marks the last clock of the bit currently on the line.
   assign bit_end  = (per_cnt == PER_LAST);
   assign in_ready = (state == IDLE);
   assign busy     = ~in_ready;
   assign done     = (state == STOP) && bit_end && (rep_cnt == 2'd0);

   always_comb begin
      state_nx   = state;
      shreg_nx   = shreg;
      hold_nx    = hold;
      bit_cnt_nx = bit_cnt;
      rep_cnt_nx = rep_cnt;
      per_cnt_nx = '0;
      x_nx       = 1'b0;

      // The bit-period counter restarts at every bit boundary.  Because of
      // that restart, it can never count past PER_LAST.
      if (state != IDLE && !bit_end)
         per_cnt_nx = per_cnt + 1'b1;

      case (state)
         IDLE: begin
            if (in_valid) begin
               shreg_nx   = in_data;
               hold_nx    = in_data;
               rep_cnt_nx = in_rep;
               bit_cnt_nx = '0;
               state_nx   = START;
            end
         end
         START: begin
            if (bit_end) begin
               bit_cnt_nx = '0;
               state_nx   = DATA;
            end
         end
         DATA: begin
            if (bit_end) begin
               shreg_nx = shreg << 1;
               if (bit_cnt == BIT_LAST)
                  state_nx = STOP;
               else
                  bit_cnt_nx = bit_cnt + 1'b1;
            end
         end
         STOP: begin
            if (bit_end) begin
               if (rep_cnt != 2'd0) begin
                  // Repeat: rebuild the shift register from the held copy.
                  // The live in_data port may have changed since the load.
                  rep_cnt_nx = rep_cnt - 2'd1;
                  shreg_nx   = hold;
                  state_nx   = START;
               end else begin
                  state_nx = IDLE;
               end
            end
         end
         default: state_nx = IDLE;
      endcase

      // x is decoded from the next state and next shift register, then
      // registered.  The registered x therefore matches the state it
      // belongs to, with no glitches.
      case (state_nx)
         START:   x_nx = 1'b1;
         DATA:    x_nx = shreg_nx[WIDTH-1];
         default: x_nx = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         shreg   <= '0;
         hold    <= '0;
         bit_cnt <= '0;
         per_cnt <= '0;
         rep_cnt <= '0;
         x       <= 1'b0;
      end else begin
         state   <= state_nx;
         shreg   <= shreg_nx;
         hold    <= hold_nx;
         bit_cnt <= bit_cnt_nx;
         per_cnt <= per_cnt_nx;
         rep_cnt <= rep_cnt_nx;
         x       <= x_nx;
      end
   end

endmodule
